// File: rtl/tl_imem_responder.sv
// tl_imem_responder: TileLink-UH D-channel responder serving instruction fetch bursts from an on-chip memory.
module tl_imem_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int          DEPTH_WORDS = 4096,
    parameter int          MAX_SIZE    = 5,
    parameter string       INIT_FILE   = ""
) (
    input  logic        core_clock_i,
    input  logic        core_reset_i,
    input  logic [2:0]  a_opcode,
    input  logic [2:0]  a_param,
    input  logic [3:0]  a_size,
    input  logic [31:0] a_address,
    input  logic [3:0]  a_mask,
    input  logic [31:0] a_data,
    input  logic        a_corrupt,
    input  logic        a_valid,
    output logic        a_ready,
    output logic [2:0]  d_opcode,
    output logic [1:0]  d_param,
    output logic [3:0]  d_size,
    output logic        d_denied,
    output logic [31:0] d_data,
    output logic        d_corrupt,
    output logic        d_valid,
    input  logic        d_ready
);
    localparam int AW = $clog2(DEPTH_WORDS);
    typedef enum logic {IDLE, RESP} state_t;
    typedef enum logic [1:0] {CLS_OK, CLS_PUTDENY, CLS_GETDENY} cls_t;
    state_t state, state_n;
    cls_t cls, cls_n;
    logic [3:0] size, beat, last, last_n;
    logic [AW-1:0] idx, raddr;
    logic [31:0] rdata, offset, amask;
    logic [31:0] mem [DEPTH_WORDS];
    logic accept, fire, get_ok, unused;
    initial begin
        for (int i = 0; i < DEPTH_WORDS; i++) mem[i] = '0;
    end
    assign unused = ^{a_param, a_mask, a_data, a_corrupt};
    assign offset = a_address - BASE_ADDR;
    assign amask  = (32'd1 << a_size) - 32'd1;
    assign get_ok = a_opcode == 3'd4 && a_size <= 4'(MAX_SIZE) && (offset & amask) == 32'd0
                    && {1'b0, offset} < 33'(DEPTH_WORDS) * 33'd4;
    assign cls_n  = (a_opcode == 3'd0 || a_opcode == 3'd1) ? CLS_PUTDENY : get_ok ? CLS_OK : CLS_GETDENY;
    assign last_n = (cls_n == CLS_PUTDENY || a_size <= 4'd2) ? 4'd0
                    : 4'((16'd1 << (a_size - 4'd2)) - 16'd1);
    assign a_ready = state == IDLE && !core_reset_i;
    assign accept  = a_valid && a_ready;
    assign fire    = d_valid && d_ready;
    assign raddr   = state == IDLE ? offset[AW+1:2] : fire ? idx + 1'b1 : idx;
    always_ff @(posedge core_clock_i) begin
        state <= core_reset_i ? IDLE : state_n;
    end
    always_comb begin
        state_n   = state;
        d_valid   = 1'b0;
        d_opcode  = 3'd0;
        d_param   = 2'd0;
        d_size    = size;
        d_denied  = 1'b0;
        d_corrupt = 1'b0;
        d_data    = 32'd0;
        state_n   = accept ? RESP : (fire && beat == last) ? IDLE : state;
        d_valid   = state == RESP;
        d_opcode  = (state == RESP && cls != CLS_PUTDENY) ? 3'd1 : 3'd0;
        d_denied  = state == RESP && cls != CLS_OK;
        d_corrupt = state == RESP && cls == CLS_GETDENY;
        d_data    = (state == RESP && cls == CLS_OK) ? rdata : 32'd0;
    end
    always_ff @(posedge core_clock_i) begin
        if (core_reset_i) begin
            cls  <= CLS_OK;
            size <= 4'd0;
            last <= 4'd0;
            beat <= 4'd0;
            idx  <= '0;
        end else if (accept) begin
            cls  <= cls_n;
            size <= a_size;
            last <= last_n;
            beat <= 4'd0;
            idx  <= offset[AW+1:2];
        end else if (fire) begin
            beat <= beat + 4'd1;
            idx  <= idx + 1'b1;
        end
    end
    always_ff @(posedge core_clock_i) begin
        rdata <= mem[raddr];
    end
endmodule

// File: tb/tb_tl_imem_responder.sv
// tb_tl_imem_responder: directed bench for the instruction-memory TileLink responder.
module tb_tl_imem_responder;
    logic        clk = 1'b0, rst = 1'b1;
    logic [2:0]  a_opcode = 3'd0, a_param = 3'd0;
    logic [3:0]  a_size = 4'd0, a_mask = 4'hf;
    logic [31:0] a_address = 32'd0, a_data = 32'd0;
    logic        a_corrupt = 1'b0, a_valid = 1'b0, a_ready;
    logic [2:0]  d_opcode;
    logic [1:0]  d_param;
    logic [3:0]  d_size;
    logic        d_denied, d_corrupt, d_valid, d_ready = 1'b1;
    logic [31:0] d_data;
    int checks = 0, errors = 0;
    bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    tl_imem_responder dut (
        .core_clock_i(clk), .core_reset_i(rst),
        .a_opcode(a_opcode), .a_param(a_param), .a_size(a_size), .a_address(a_address),
        .a_mask(a_mask), .a_data(a_data), .a_corrupt(a_corrupt), .a_valid(a_valid), .a_ready(a_ready),
        .d_opcode(d_opcode), .d_param(d_param), .d_size(d_size), .d_denied(d_denied),
        .d_data(d_data), .d_corrupt(d_corrupt), .d_valid(d_valid), .d_ready(d_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input string tag, input logic [2:0] op, input logic [3:0] sz,
                        input logic [31:0] addr, input int nbeats, input logic [2:0] eop,
                        input logic eden, input logic ecor, input logic [31:0] dbase,
                        input bit ok, input bit stall);
        int beats = 0, cyc = 0;
        bit rdy;
        @(negedge clk);
        a_valid = 1'b1; a_opcode = op; a_size = sz; a_address = addr; a_data = 32'hdeadbeef;
        check({tag, ".a_ready_idle"}, a_ready, 1);
        @(negedge clk);
        a_valid = 1'b0;
        while (beats < nbeats && cyc < 200) begin
            rdy = stall ? pat[cyc % 6] : 1'b1;
            d_ready = rdy;
            check({tag, ".d_valid"}, d_valid, 1);
            check({tag, ".a_ready_busy"}, a_ready, 0);
            check({tag, ".d_opcode"}, d_opcode, eop);
            check({tag, ".d_param"}, d_param, 0);
            check({tag, ".d_size"}, d_size, sz);
            check({tag, ".d_denied"}, d_denied, eden);
            check({tag, ".d_corrupt"}, d_corrupt, ecor);
            check({tag, ".d_data"}, d_data, ok ? dbase + 32'(beats) : 32'd0);
            @(negedge clk);
            if (rdy) beats++;
            cyc++;
        end
        d_ready = 1'b1;
        check({tag, ".beats"}, beats, nbeats);
        if (!stall) check({tag, ".cycles"}, cyc, nbeats);
        check({tag, ".d_valid_end"}, d_valid, 0);
        check({tag, ".a_ready_end"}, a_ready, 1);
    endtask

    initial begin
        #1;
        for (int i = 0; i < 64; i++) dut.mem[i] = 32'(i);
        repeat (2) @(negedge clk);
        check("rst.a_ready", a_ready, 0);
        check("rst.d_valid", d_valid, 0);
        check("rst.d_opcode", d_opcode, 0);
        check("rst.d_size", d_size, 0);
        check("rst.d_denied", d_denied, 0);
        check("rst.d_corrupt", d_corrupt, 0);
        check("rst.d_data", d_data, 0);
        rst = 1'b0;
        #1 check("rst.a_ready_release", a_ready, 1);

        xfer("get32", 3'd4, 4'd5, 32'h40, 8, 3'd1, 1'b0, 1'b0, 32'd16, 1'b1, 1'b0);
        xfer("get32_stall", 3'd4, 4'd5, 32'h40, 8, 3'd1, 1'b0, 1'b0, 32'd16, 1'b1, 1'b1);
        xfer("oob", 3'd4, 4'd2, 32'h4000, 1, 3'd1, 1'b1, 1'b1, 32'd0, 1'b0, 1'b0);
        xfer("misalign", 3'd4, 4'd5, 32'h44, 8, 3'd1, 1'b1, 1'b1, 32'd0, 1'b0, 1'b0);
        xfer("oversize", 3'd4, 4'd6, 32'h40, 16, 3'd1, 1'b1, 1'b1, 32'd0, 1'b0, 1'b1);
        xfer("badop", 3'd5, 4'd2, 32'h8, 1, 3'd1, 1'b1, 1'b1, 32'd0, 1'b0, 1'b0);
        xfer("put0", 3'd0, 4'd2, 32'h0, 1, 3'd0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        xfer("get0", 3'd4, 4'd2, 32'h0, 1, 3'd1, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
        xfer("putp50", 3'd1, 4'd2, 32'h50, 1, 3'd0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
        xfer("get50", 3'd4, 4'd2, 32'h50, 1, 3'd1, 1'b0, 1'b0, 32'd20, 1'b1, 1'b0);
        xfer("get16", 3'd4, 4'd4, 32'h20, 4, 3'd1, 1'b0, 1'b0, 32'd8, 1'b1, 1'b1);

        @(negedge clk);
        a_valid = 1'b1; a_opcode = 3'd4; a_size = 4'd5; a_address = 32'h0;
        @(negedge clk);
        a_valid = 1'b0;
        check("abort.beat0", d_data, 0);
        @(negedge clk);
        check("abort.beat1", d_data, 1);
        @(negedge clk);
        check("abort.beat2", d_data, 2);
        rst = 1'b1;
        @(negedge clk);
        check("abort.d_valid", d_valid, 0);
        check("abort.a_ready_rst", a_ready, 0);
        rst = 1'b0;
        #1 check("abort.a_ready", a_ready, 1);
        xfer("after_abort", 3'd4, 4'd2, 32'h4, 1, 3'd1, 1'b0, 1'b0, 32'd1, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
